// File: rtl/fetch_sequencer.sv
// Instruction fetch / PC sequencer: request-ready fetch, holds the word until
// the datapath retires it, applies redirects and halts on EBREAK, step or fault.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT        = 16,
    parameter bit          HALT_ON_EBREAK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        step_mode,
    input  logic        resume,
    output logic [31:0] pc,
    output logic        halted,
    output logic [1:0]  err_code,
    output logic [31:0] retire_count
);

    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
    localparam int          TW          = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    state_t         state_reg;
    logic [31:0]    pc_reg;
    logic [31:0]    instr_reg;
    logic           instr_valid_reg;
    logic           imem_req_reg;
    logic           halted_reg;
    logic [1:0]     err_code_reg;
    logic [31:0]    retire_count_reg;
    logic [TW-1:0]  tcount_reg;

    assign imem_req     = imem_req_reg;
    assign imem_addr    = pc_reg;
    assign pc           = pc_reg;
    assign instr        = instr_reg;
    assign instr_valid  = instr_valid_reg;
    assign halted       = halted_reg;
    assign err_code     = err_code_reg;
    assign retire_count = retire_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_FETCH;
            pc_reg           <= RESET_PC;
            instr_reg        <= 32'h0;
            instr_valid_reg  <= 1'b0;
            imem_req_reg     <= 1'b0;
            halted_reg       <= 1'b0;
            err_code_reg     <= 2'd0;
            retire_count_reg <= 32'h0;
            tcount_reg       <= '0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    // After reset FETCH is entered with the request low; raise it here.
                    if (!imem_req_reg) begin
                        imem_req_reg <= 1'b1;
                        tcount_reg   <= '0;
                    end else if (imem_ready) begin
                        instr_reg       <= imem_rdata;
                        instr_valid_reg <= 1'b1;
                        imem_req_reg    <= 1'b0;
                        state_reg       <= ST_EXEC;
                    end else if (tcount_reg == TW'(TIMEOUT - 1)) begin
                        tcount_reg   <= tcount_reg + 1'b1;
                        err_code_reg <= 2'd1;
                        halted_reg   <= 1'b1;
                        imem_req_reg <= 1'b0;
                        state_reg    <= ST_HALT;
                    end else begin
                        tcount_reg <= tcount_reg + 1'b1;
                    end
                end

                ST_EXEC: begin
                    if (instr_ack) begin
                        instr_valid_reg  <= 1'b0;
                        retire_count_reg <= retire_count_reg + 32'd1;
                        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                            // Misaligned target: retire but keep pc for the debugger.
                            err_code_reg <= 2'd2;
                            halted_reg   <= 1'b1;
                            state_reg    <= ST_HALT;
                        end else begin
                            pc_reg <= redirect_valid ? redirect_target : pc_reg + 32'd4;
                            if (HALT_ON_EBREAK && (instr_reg == EBREAK_WORD)) begin
                                halted_reg <= 1'b1;
                                state_reg  <= ST_HALT;
                            end else if (step_mode) begin
                                halted_reg <= 1'b1;
                                state_reg  <= ST_HALT;
                            end else begin
                                imem_req_reg <= 1'b1;
                                tcount_reg   <= '0;
                                state_reg    <= ST_FETCH;
                            end
                        end
                    end
                end

                ST_HALT: begin
                    // Errors are sticky: only reset leaves a faulted halt.
                    if (resume && (err_code_reg == 2'd0)) begin
                        halted_reg   <= 1'b0;
                        imem_req_reg <= 1'b1;
                        tcount_reg   <= '0;
                        state_reg    <= ST_FETCH;
                    end
                end

                default: begin
                    state_reg <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random fetch/retire traffic,
// checked by a queue-based scoreboard against a transaction-level PC model.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        step_mode = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] pc;
    logic        halted;
    logic [1:0]  err_code;
    logic [31:0] retire_count;

    fetch_sequencer #(
        .RESET_PC(RESET_PC),
        .TIMEOUT(TIMEOUT),
        .HALT_ON_EBREAK(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ack(instr_ack),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .step_mode(step_mode),
        .resume(resume),
        .pc(pc),
        .halted(halted),
        .err_code(err_code),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] retire;
        logic        halted;
        logic [1:0]  err;
    } retire_t;

    fetch_t  fq[$];
    retire_t rq[$];
    int checks = 0;
    int errors = 0;

    // Architectural model: where the program counter should be and what has retired.
    logic [31:0] m_pc;
    logic [31:0] m_retire;
    logic        m_halted;
    logic [1:0]  m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever a fetch is presented or an instruction retires.
    initial begin
        logic        prev_valid;
        logic [31:0] prev_retire;
        fetch_t      fe;
        retire_t     re;
        prev_valid  = 1'b0;
        prev_retire = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (instr_valid && !prev_valid) begin
                    if (fq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fetch: got pc %h expected no fetch", pc);
                    end else begin
                        fe = fq.pop_front();
                        check("fetch_pc", pc, fe.pc);
                        check("fetch_instr", instr, fe.instr);
                        $display("fetch  pc=%h instr=%h", pc, instr);
                    end
                end
                if (retire_count != prev_retire) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_retire: got retire_count %0d expected %0d", retire_count, prev_retire);
                    end else begin
                        re = rq.pop_front();
                        check("retire_pc", pc, re.pc);
                        check("retire_count", retire_count, re.retire);
                        check("retire_halted", 32'(halted), 32'(re.halted));
                        check("retire_err", 32'(err_code), 32'(re.err));
                        $display("retire count=%0d pc=%h halted=%0d err=%0d", retire_count, pc, halted, err_code);
                    end
                end
            end
            prev_valid  = instr_valid;
            prev_retire = retire_count;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        imem_ready = 1'b0;
        instr_ack = 1'b0;
        redirect_valid = 1'b0;
        resume = 1'b0;
        step_mode = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        fq.delete();
        rq.delete();
        m_pc = RESET_PC;
        m_retire = 32'h0;
        m_halted = 1'b0;
        m_err = 2'd0;
        check("rst_pc", pc, RESET_PC);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_req", 32'(imem_req), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_err", 32'(err_code), 0);
        check("rst_retire", retire_count, 0);
        $display("reset  pc=%h", pc);
    endtask

    task automatic run_fetch(input int lat, input logic [31:0] word, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        // Ready pulses while no request is outstanding must be ignored.
        while (!imem_req && n < 20) begin
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            @(negedge clk);
            n++;
        end
        imem_ready = 1'b0;
        if (!imem_req) begin
            checks++;
            errors++;
            $display("FAIL req_wait: got imem_req 0 expected 1 within 20 cycles");
            return;
        end
        check("imem_addr", imem_addr, m_pc);
        fq.push_back('{pc: m_pc, instr: word});
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("req_held", 32'(imem_req), 1);
            check("pc_stable", pc, m_pc);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check("req_drop", 32'(imem_req), 0);
        ok = 1'b1;
    endtask

    task automatic do_ack(input int dly, input logic [31:0] word, input bit redir,
                          input logic [31:0] tgt, input bit step);
        for (int i = 0; i < dly; i++) begin
            redirect_valid  = 1'($urandom_range(0, 1));
            redirect_target = $urandom;
            resume          = 1'($urandom_range(0, 1));
            step_mode       = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("hold_valid", 32'(instr_valid), 1);
        check("hold_instr", instr, word);
        m_retire = m_retire + 32'd1;
        if (redir && tgt[1:0] != 2'b00) begin
            m_err = 2'd2;
            m_halted = 1'b1;
        end else begin
            m_pc = redir ? tgt : m_pc + 32'd4;
            if (word == EBREAK || step) m_halted = 1'b1;
        end
        rq.push_back('{pc: m_pc, retire: m_retire, halted: m_halted, err: m_err});
        instr_ack = 1'b1;
        redirect_valid = redir;
        redirect_target = tgt;
        step_mode = step;
        resume = 1'b0;
        @(negedge clk);
        instr_ack = 1'b0;
        redirect_valid = 1'b0;
        step_mode = 1'b0;
        check("ack_clears_valid", 32'(instr_valid), 0);
    endtask

    task automatic handle_halt();
        if (!m_halted) return;
        check("halt_flag", 32'(halted), 1);
        repeat (2) begin
            imem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        imem_ready = 1'b0;
        check("halt_no_req", 32'(imem_req), 0);
        check("halt_no_valid", 32'(instr_valid), 0);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        if (m_err == 2'd0) begin
            check("resume_halted", 32'(halted), 0);
            check("resume_req", 32'(imem_req), 1);
            check("resume_addr", imem_addr, m_pc);
            m_halted = 1'b0;
            $display("resume pc=%h", pc);
        end else begin
            @(negedge clk);
            check("err_resume_halted", 32'(halted), 1);
            check("err_sticky", 32'(err_code), 32'(m_err));
            check("err_no_req", 32'(imem_req), 0);
            do_reset();
        end
    endtask

    task automatic one_instr(input int lat, input logic [31:0] word, input int dly,
                             input bit redir, input logic [31:0] tgt, input bit step);
        bit ok;
        run_fetch(lat, word, ok);
        if (!ok) begin
            do_reset();
            return;
        end
        do_ack(dly, word, redir, tgt, step);
        handle_halt();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit ok;
        int lat;
        int dly;
        int r;
        bit redir;
        bit step;
        logic [31:0] word;
        logic [31:0] tgt;

        do_reset();

        // Back-to-back sequential fetches: pc 0, 4, 8 then 12.
        repeat (3) one_instr(0, NOP, 0, 1'b0, 32'h0, 1'b0);
        check("seq_pc", pc, 32'd12);
        check("seq_retire", retire_count, 32'd3);
        check("seq_err", 32'(err_code), 0);

        one_instr(3, NOP, 0, 1'b0, 32'h0, 1'b0);
        one_instr(0, NOP, 1, 1'b1, 32'h100, 1'b0);
        one_instr(0, NOP, 0, 1'b1, 32'h102, 1'b0);

        one_instr(0, EBREAK, 0, 1'b0, 32'h0, 1'b0);
        one_instr(0, NOP, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        one_instr(0, NOP, 0, 1'b0, 32'h0, 1'b0);
        check("wrap_pc", pc, 32'h0);

        repeat (3) one_instr(1, NOP, 0, 1'b0, 32'h0, 1'b1);

        // Fetch timeout: memory never answers.
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
        check("timeout_halted", 32'(halted), 1);
        check("timeout_err", 32'(err_code), 1);
        $display("timeout after %0d request cycles err=%0d", n, err_code);
        m_halted = 1'b1;
        m_err = 2'd1;
        handle_halt();

        // Reset while an instruction waits in EXEC at pc 0x40.
        one_instr(0, NOP, 0, 1'b1, 32'h40, 1'b0);
        run_fetch(0, NOP, ok);
        check("midexec_pc", pc, 32'h40);
        @(negedge clk);
        do_reset();
        @(negedge clk);
        check("restart_req", 32'(imem_req), 1);
        check("restart_addr", imem_addr, RESET_PC);

        for (int i = 0; i < 150; i++) begin
            lat  = $urandom_range(0, 5);
            dly  = $urandom_range(0, 3);
            word = ($urandom_range(0, 9) == 0) ? EBREAK : $urandom;
            redir = ($urandom_range(0, 3) == 0);
            step  = ($urandom_range(0, 7) == 0);
            tgt = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0)      tgt[1:0] = 2'($urandom_range(1, 3));
            else if (r == 1) tgt = 32'hFFFF_FFFC;
            else             tgt[1:0] = 2'b00;
            one_instr(lat, word, dly, redir, tgt, step);
        end

        @(negedge clk);
        check("fq_empty", 32'(fq.size()), 0);
        check("rq_empty", 32'(rq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls instruction fetch and program-counter sequencing for the core. It replaces the free-running "pc + 4 every cycle" arrangement.
- Issues a request/ready fetch to instruction memory and holds the fetched word for the datapath until the datapath acknowledges it.
- Applies branch/jump redirects and halts on EBREAK, on single-step, or on a fault.
- Sits between program_counter/instruction_memory and control_unit. It owns the PC write enable.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- TIMEOUT, 16: maximum number of cycles imem_req may stay high without imem_ready; must be >= 1.
- HALT_ON_EBREAK, 1: when 1, retiring 32'h0010_0073 enters HALT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals pc
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  held instruction for the datapath
- instr_valid  out  1  instr is valid
- instr_ack  in  1  datapath has consumed/retired instr
- redirect_valid  in  1  next PC is redirect_target (sampled only with instr_ack)
- redirect_target  in  32  branch/jump target
- step_mode  in  1  level; halt after every retired instruction
- resume  in  1  pulse; leave HALT
- pc  out  32  current PC
- halted  out  1  sequencer in HALT
- err_code  out  2  0 none, 1 fetch timeout, 2 misaligned redirect; sticky
- retire_count  out  32  instructions retired since reset

Behaviour:
- Reset (synchronous, wins over every other input in the same edge, including mid-fetch):
  - pc = RESET_PC, state = FETCH, instr = 0.
  - instr_valid = 0, imem_req = 0, halted = 0, err_code = 0, retire_count = 0, timeout counter = 0.
- All outputs are registered. imem_addr is pc.
- States: FETCH, EXEC, HALT.
- FETCH:
  - imem_req = 1 from the first cycle after reset or after entering FETCH.
  - When imem_req & imem_ready: instr <= imem_rdata, instr_valid <= 1, imem_req <= 0, state <= EXEC. Minimum latency is 1 cycle from ready to instr_valid.
  - Timeout counter increments on each cycle with imem_req=1 and imem_ready=0. Reaching TIMEOUT sets err_code=1, halted=1, imem_req=0, state=HALT.
  - The counter clears on each new FETCH entry.
- imem_ready while imem_req=0 is ignored.
- EXEC:
  - instr and instr_valid are held stable until instr_ack.
  - On instr_ack, the cycle after the ack: instr_valid=0 and retire_count increments by 1 (wraps at 2^32).
  - pc <= redirect_valid ? redirect_target : pc + 4. The addition is modulo 2^32, so 32'hFFFF_FFFC becomes 0.
  - If redirect_valid and redirect_target[1:0] != 0: the instruction still retires, but pc is unchanged, err_code=2, and state=HALT.
  - Otherwise, if HALT_ON_EBREAK and instr == 32'h0010_0073: state=HALT (pc already advanced).
  - Otherwise, if step_mode: state=HALT.
  - Otherwise: state=FETCH.
  - redirect_valid without instr_ack is ignored.
- HALT:
  - halted=1, imem_req=0, instr_valid=0.
  - resume with err_code==0: halted=0 and state=FETCH on the next edge.
  - resume with err_code!=0 is ignored; only reset clears an error.
- Simultaneous events:
  - resume is ignored outside HALT.
  - step_mode is sampled at the instr_ack edge.

Test Plan:
- Reset, imem_ready one cycle after each request, instr_ack one cycle after each instr_valid, 3 instructions -> pc steps 0, 4, 8, 12; retire_count=3; no errors.
- imem_ready delayed 3 cycles -> imem_req held high 4 cycles, instr_valid one cycle after ready, pc stable throughout.
- instr_ack with redirect_valid=1, target 32'h100 -> next imem_addr=32'h100. Then target 32'h102 -> err_code=2, halted=1, pc unchanged, retire_count still increments.
- Fetch returns 32'h0010_0073, then ack -> halted=1, pc = old pc + 4. resume -> fetch resumes at that pc.
- imem_ready never asserted with TIMEOUT=16 -> after 16 request cycles err_code=1, halted=1. resume ignored; reset clears.
- step_mode=1 -> exactly one retire per resume pulse. Reset asserted mid-EXEC with pc=32'h40 -> pc=RESET_PC, instr_valid=0, and FETCH restarts next cycle.
